// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: debounced run/clear/lap buttons drive a 0..9999 counter
// whose live or lap-frozen value is presented on fndData for the FND display.
module stopwatch_ctrl #(
    parameter int TICK_DIV  = 1_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_run,
    input  logic        btn_clear,
    input  logic        btn_lap,
    output logic [13:0] fndData,
    output logic        running,
    output logic        lap_active,
    output logic        wrap
);

    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int PSW = $clog2(TICK_DIV + 1);
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam logic [PSW-1:0] TICK_LAST = PSW'(TICK_DIV - 1);
    localparam logic [13:0]    CNT_MAX   = 14'd9999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    // Bit order for all button vectors: [0] run, [1] clear, [2] lap.
    logic [2:0]           btn_raw_s;
    logic [2:0]           sync1_q, sync2_q;
    logic [2:0]           acc_q, acc_d;
    logic [2:0]           press_q, press_d;
    logic [2:0][DBW-1:0]  db_cnt_q, db_cnt_d;

    state_e               state_q, state_d;
    logic [PSW-1:0]       pre_q, pre_d;
    logic [13:0]          count_q, count_d;
    logic [13:0]          lap_val_q, lap_val_d;
    logic                 lap_on_q, lap_on_d;
    logic                 wrap_q, wrap_d;
    logic [13:0]          fnd_q;
    logic                 run_q;

    logic                 clr_s, run_s, lap_s, tick_s;

    assign btn_raw_s = {btn_lap, btn_clear, btn_run};

    // Debounce: accept a new level once it has differed for DB_CYCLES samples.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            acc_d[i]    = acc_q[i];
            press_d[i]  = 1'b0;
            db_cnt_d[i] = '0;
            if (sync2_q[i] != acc_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    acc_d[i]   = sync2_q[i];
                    press_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
                end
            end else begin
                db_cnt_d[i] = '0;
            end
        end
    end

    // Button synchronisers, debounce counters and press pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 3'b000;
            sync2_q  <= 3'b000;
            acc_q    <= 3'b000;
            press_q  <= 3'b000;
            db_cnt_q <= '0;
        end else begin
            sync1_q  <= btn_raw_s;
            sync2_q  <= sync1_q;
            acc_q    <= acc_d;
            press_q  <= press_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // Only the highest-priority press of a cycle survives: clear > run > lap.
    assign clr_s  = press_q[1];
    assign run_s  = press_q[0] & ~press_q[1];
    assign lap_s  = press_q[2] & ~press_q[1] & ~press_q[0];
    assign tick_s = (state_q == ST_RUN) && (pre_q == TICK_LAST);

    // Next-state logic for the controller, prescaler, counter and lap register.
    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        count_d   = count_q;
        lap_val_d = lap_val_q;
        lap_on_d  = lap_on_q;
        wrap_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pre_d = '0;
                if (run_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (tick_s) begin
                    pre_d   = '0;
                    wrap_d  = (count_q == CNT_MAX);
                    count_d = (count_q == CNT_MAX) ? 14'd0 : count_q + 14'd1;
                end else begin
                    pre_d = pre_q + PSW'(1);
                end
                if (run_s) begin
                    state_d = ST_PAUSE;
                end else if (lap_s) begin
                    // Lap captures the pre-increment count when a tick coincides.
                    lap_on_d = ~lap_on_q;
                    if (!lap_on_q) begin
                        lap_val_d = count_q;
                    end else begin
                        lap_val_d = lap_val_q;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (clr_s) begin
                    state_d   = ST_IDLE;
                    count_d   = 14'd0;
                    lap_val_d = 14'd0;
                    lap_on_d  = 1'b0;
                end else if (run_s) begin
                    state_d = ST_RUN;
                end else if (lap_s) begin
                    lap_on_d = 1'b0;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                pre_d     = '0;
                count_d   = 14'd0;
                lap_val_d = 14'd0;
                lap_on_d  = 1'b0;
            end
        endcase
    end

    // Controller state and registered outputs, driven from next-state values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pre_q     <= '0;
            count_q   <= 14'd0;
            lap_val_q <= 14'd0;
            lap_on_q  <= 1'b0;
            wrap_q    <= 1'b0;
            fnd_q     <= 14'd0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            count_q   <= count_d;
            lap_val_q <= lap_val_d;
            lap_on_q  <= lap_on_d;
            wrap_q    <= wrap_d;
            fnd_q     <= lap_on_d ? lap_val_d : count_d;
            run_q     <= (state_d == ST_RUN);
        end
    end

    assign fndData    = fnd_q;
    assign running    = run_q;
    assign lap_active = lap_on_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed vector table, hand-written
// corner sequences and random button traffic compared against a cycle model.
module tb_stopwatch_ctrl;

    localparam int TICK = 4;
    localparam int DB   = 3;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        btn_run = 1'b0, btn_clear = 1'b0, btn_lap = 1'b0;
    logic [13:0] fndData;
    logic        running, lap_active, wrap;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    stopwatch_ctrl #(.TICK_DIV(TICK), .DB_CYCLES(DB)) dut (
        .clk(clk), .reset(reset),
        .btn_run(btn_run), .btn_clear(btn_clear), .btn_lap(btn_lap),
        .fndData(fndData), .running(running), .lap_active(lap_active), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int s1[3], s2[3], acc[3], press[3];
    int hist[3][DB];
    int mode = M_IDLE, phase = 0, m_cnt = 0, lapv = 0, lapon = 0;
    int m_fnd = 0, m_run = 0, m_wrap = 0;

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            s1[b] = 0; s2[b] = 0; acc[b] = 0; press[b] = 0;
            for (int j = 0; j < DB; j++) hist[b][j] = 0;
        end
        mode = M_IDLE; phase = 0; m_cnt = 0; lapv = 0; lapon = 0;
        m_fnd = 0; m_run = 0; m_wrap = 0;
    endtask

    task automatic model_step();
        int clr, rn, lp, tk, all, npress[3], raw[3];
        raw[0] = int'(btn_run); raw[1] = int'(btn_clear); raw[2] = int'(btn_lap);
        clr = press[1];
        rn  = (press[0] != 0 && clr == 0) ? 1 : 0;
        lp  = (press[2] != 0 && clr == 0 && rn == 0) ? 1 : 0;
        tk  = (mode == M_RUN && phase == TICK - 1) ? 1 : 0;
        m_wrap = 0;
        if (mode == M_RUN) begin
            phase = tk ? 0 : phase + 1;
            if (tk) begin
                m_wrap = (m_cnt == 9999) ? 1 : 0;
                m_cnt  = (m_cnt + 1) % 10000;
            end
            if (rn) mode = M_PAUSE;
            else if (lp) begin
                if (lapon) lapon = 0;
                else begin
                    lapon = 1;
                    lapv  = (tk && m_cnt == 0) ? 9999 : (tk ? m_cnt - 1 : m_cnt);
                end
            end
        end else if (mode == M_PAUSE) begin
            if (clr) begin mode = M_IDLE; m_cnt = 0; lapv = 0; lapon = 0; end
            else if (rn) mode = M_RUN;
            else if (lp) lapon = 0;
        end else begin
            phase = 0;
            if (rn) mode = M_RUN;
        end
        m_fnd = lapon ? lapv : m_cnt;
        m_run = (mode == M_RUN) ? 1 : 0;
        // Level accepted once the last DB synced samples all disagree with it.
        for (int b = 0; b < 3; b++) begin
            for (int j = DB - 1; j > 0; j--) hist[b][j] = hist[b][j-1];
            hist[b][0] = s2[b];
            all = 1;
            for (int j = 0; j < DB; j++) if (hist[b][j] == acc[b]) all = 0;
            npress[b] = 0;
            if (all) begin acc[b] = s2[b]; npress[b] = s2[b]; end
            s2[b] = s1[b];
            s1[b] = raw[b];
        end
        for (int b = 0; b < 3; b++) press[b] = npress[b];
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else        model_step();
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_fnd",  int'(fndData),    m_fnd);
            chk("model_run",  int'(running),    m_run);
            chk("model_lap",  int'(lap_active), lapon);
            chk("model_wrap", int'(wrap),       m_wrap);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive(input logic [2:0] b);
        btn_run = b[0]; btn_clear = b[1]; btn_lap = b[2];
    endtask

    task automatic press_btn(input logic [2:0] b, input int hold, input int gap);
        drive(b); cyc(hold); drive(3'b000); cyc(gap);
    endtask

    task automatic wait_model(input string name, input bit use_cnt, input int val, input int budget);
        int n = 0;
        while (((use_cnt ? m_cnt : m_fnd) != val) && n < budget) begin cyc(1); n++; end
        if (n >= budget) chk({name, "_timeout"}, n, 0);
    endtask

    typedef struct {
        logic [2:0] btn;
        int         hold;
        int         gap;
        logic       exp_run;
        logic       exp_lap;
        int         exp_fnd;   // -1: value checked by the model only
    } vec_t;

    vec_t tbl[15];

    initial begin
        int frozen, wraps;
        tbl[0]  = '{3'b001,  2, 10, 1'b0, 1'b0,  0};   // bounce in IDLE
        tbl[1]  = '{3'b001, 10, 40, 1'b1, 1'b0, -1};   // start
        tbl[2]  = '{3'b100, 10, 20, 1'b1, 1'b1, -1};   // lap freeze
        tbl[3]  = '{3'b100, 10, 20, 1'b1, 1'b0, -1};   // lap release
        tbl[4]  = '{3'b010, 10, 10, 1'b1, 1'b0, -1};   // clear ignored in RUN
        tbl[5]  = '{3'b100, 10, 10, 1'b1, 1'b1, -1};
        tbl[6]  = '{3'b001, 10, 10, 1'b0, 1'b1, -1};   // pause keeps lap
        tbl[7]  = '{3'b100, 10, 10, 1'b0, 1'b0, -1};   // lap clears in PAUSE
        tbl[8]  = '{3'b100, 10, 10, 1'b0, 1'b0, -1};   // lap never sets in PAUSE
        tbl[9]  = '{3'b010, 10, 10, 1'b0, 1'b0,  0};   // clear -> IDLE
        tbl[10] = '{3'b100, 10, 10, 1'b0, 1'b0,  0};   // lap ignored in IDLE
        tbl[11] = '{3'b001, 10, 20, 1'b1, 1'b0, -1};
        tbl[12] = '{3'b001, 10, 10, 1'b0, 1'b0, -1};
        tbl[13] = '{3'b011, 10, 10, 1'b0, 1'b0,  0};   // run+clear in PAUSE
        tbl[14] = '{3'b111, 10, 10, 1'b0, 1'b0,  0};   // clear wins in IDLE

        cyc(3);
        chk("reset_fnd",  int'(fndData),    0);
        chk("reset_run",  int'(running),    0);
        chk("reset_lap",  int'(lap_active), 0);
        chk("reset_wrap", int'(wrap),       0);
        reset = 1'b1;
        chk_en = 1'b1;
        cyc(2);

        for (int i = 0; i < 15; i++) begin
            press_btn(tbl[i].btn, tbl[i].hold, tbl[i].gap);
            chk($sformatf("tbl%0d_run", i), int'(running),    int'(tbl[i].exp_run));
            chk($sformatf("tbl%0d_lap", i), int'(lap_active), int'(tbl[i].exp_lap));
            if (tbl[i].exp_fnd >= 0) chk($sformatf("tbl%0d_fnd", i), int'(fndData), tbl[i].exp_fnd);
        end

        // Run ~40 clocks, pause, then the display must hold for 100 clocks.
        press_btn(3'b001, 10, 30);
        press_btn(3'b001, 10, 2);
        chk("pause_run", int'(running), 0);
        frozen = m_fnd;
        chk("pause_nonzero", int'(fndData > 0), 1);
        for (int k = 0; k < 100; k++) begin
            cyc(1);
            if (k % 25 == 0) chk("pause_frozen", int'(fndData), frozen);
        end
        press_btn(3'b010, 10, 10);
        chk("clear_fnd", int'(fndData), 0);

        // Asynchronous reset between clock edges while counting.
        press_btn(3'b001, 10, 0);
        wait_model("reach57", 1'b0, 57, 400);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("async_fnd",  int'(fndData),    0);
        chk("async_run",  int'(running),    0);
        chk("async_lap",  int'(lap_active), 0);
        chk("async_wrap", int'(wrap),       0);
        cyc(2);
        reset = 1'b1;
        cyc(20);
        chk("post_reset_run", int'(running), 0);
        chk("post_reset_fnd", int'(fndData), 0);

        // Random button traffic, including short bounces and overlaps.
        for (int k = 0; k < 200; k++) begin
            press_btn(3'($urandom_range(0, 7)), $urandom_range(1, 12), $urandom_range(0, 20));
        end

        // Wrap 9999 -> 0 from a fresh start.
        reset = 1'b0; cyc(2); reset = 1'b1; cyc(2);
        press_btn(3'b001, 10, 0);
        wait_model("reach9998", 1'b1, 9998, 45000);
        wraps = 0;
        for (int k = 0; k < 3 * TICK; k++) begin
            cyc(1);
            if (wrap) begin
                wraps++;
                chk("wrap_fnd_zero", int'(fndData), 0);
            end
        end
        chk("wrap_count", wraps, 1);
        wait_model("reach1", 1'b1, 1, 3 * TICK);
        cyc(2);
        chk("after_wrap_fnd", int'(fndData), 1);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
